stream_demux: RTL



---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/stream_demux_if.sv | 27 ++
 rtl/stream_demux_rr_pointer.sv | 20 ++
 rtl/stream_demux.sv | 88 ++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream_demux block.
package stream_demux_pkg;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    // Wide enough for the largest supported channel count (16); callers size-cast down to N.
    function automatic logic [15:0] one_hot(input logic [3:0] idx);
        logic [15:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Valid/ready bundle for stream_demux: one input stream fanned out to N channels.
interface stream_demux_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SW = $clog2(N);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_sel;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;
    logic [WIDTH-1:0] out_data;
    logic             drop;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, drop
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, drop
    );

endinterface

// File: rtl/stream_demux_rr_pointer.sv
// Modulo-N up counter with enable; supplies round-robin destinations to stream_demux.
module rr_pointer #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [SW-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == SW'(N - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with a single holding register.
// Define STREAM_DEMUX_ROUND_ROBIN_EN to route by internal pointer instead of in_sel.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_demux_if.slave  bus
);

    localparam int SW = $clog2(N);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data_q;
    logic [SW-1:0]    dest_q;
    logic [SW-1:0]    dest_in;
    logic [N-1:0]     dest_hot;
    logic             dest_ready;
    logic             take_in;
    logic             sel_ok;
    logic             load;
    logic             drop_q;
    logic             drop_next;

    // Only the addressed sink's ready matters; the others are masked off.
    assign dest_hot   = N'(one_hot(4'(dest_q)));
    assign dest_ready = |(dest_hot & bus.out_ready);

    assign bus.in_ready  = (state == ST_EMPTY) || dest_ready;
    assign take_in       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == ST_FULL) ? dest_hot : '0;
    assign bus.out_data  = data_q;
    assign bus.drop      = drop_q;

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
    rr_pointer #(.N(N), .SW(SW)) u_rr_pointer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (take_in),
        .ptr   (dest_in)
    );
    assign sel_ok = 1'b1;
`else
    assign dest_in = bus.in_sel;
    assign sel_ok  = (int'(bus.in_sel) < N);
`endif

    // An accepted out-of-range beat never touches the holding register, but a
    // consumption on the same edge still empties it.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop_next  = take_in && !sel_ok;
        if (take_in && sel_ok) begin
            load       = 1'b1;
            state_next = ST_FULL;
        end else if ((state == ST_FULL) && dest_ready) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            dest_q <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_next;
            if (load) begin
                data_q <= bus.in_data;
                dest_q <= dest_in;
            end
        end
    end

endmodule
